// File: rtl/z180_clk_reset_gen.sv
// rtl/z180_clk_reset_gen.sv - CPU clock divider and debounced pushbutton reset sequencer for the Z8S180 top level
//
// Ports:
//   hwclk   - system clock
//   reset   - synchronous, active-high reset
//   s1_n    - raw asynchronous reset button, low = pressed
//   s2_n    - raw asynchronous step button, low = pressed (STEP_EN builds only)
//   extal   - CPU clock, 2^DIV_BITS hwclk cycles per period, 50% duty
//   reset_n - CPU reset, active low, registered, released on an extal falling edge
//   running - high while the sequencer is in RUN
//
// Optional feature macro: STEP_EN (single-step the CPU clock with s2_n while in RUN).

module z180_btn_debounce #(
    parameter int DEB_BITS = 16
) (
    input  logic hwclk,
    input  logic reset,
    input  logic btn_n,
    output logic stable
);

    logic                meta;
    logic                sync;
    logic [DEB_BITS-1:0] dcnt;

    localparam logic [DEB_BITS-1:0] DEB_MAX = '1;

    // Idle level of the buttons is high, so the synchronizer and the
    // accepted value both come out of reset as "released".
    always_ff @(posedge hwclk) begin
        if (reset) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            stable <= 1'b1;
            dcnt   <= '0;
        end else begin
            meta <= btn_n;
            sync <= meta;
            if (sync == stable) begin
                dcnt <= '0;
            end else if (dcnt == DEB_MAX) begin
                // Differed for the whole window: accept the new level.
                stable <= sync;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

module z180_clk_reset_gen #(
    parameter int DIV_BITS   = 24,
    parameter int DEB_BITS   = 16,
    parameter int RST_CYCLES = 16
) (
    input  logic hwclk,
    input  logic reset,
    input  logic s1_n,
    input  logic s2_n,
    output logic extal,
    output logic reset_n,
    output logic running
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    localparam logic [DIV_BITS-1:0] CTR_MID = {1'b0, {(DIV_BITS-1){1'b1}}};
    localparam logic [DIV_BITS-1:0] CTR_MAX = '1;
    localparam logic [RC_W-1:0]     RC_MAX  = RC_W'(RST_CYCLES);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state;
    logic [DIV_BITS-1:0] ctr;
    logic [RC_W-1:0]     rcnt;
    logic                ctr_en;
    logic                rise;
    logic                fall;
    logic                s1_stable;

    z180_btn_debounce #(
        .DEB_BITS (DEB_BITS)
    ) u_s1_deb (
        .hwclk  (hwclk),
        .reset  (reset),
        .btn_n  (s1_n),
        .stable (s1_stable)
    );

`ifdef STEP_EN
    logic s2_stable;
    logic s2_prev;
    logic step_pend;

    z180_btn_debounce #(
        .DEB_BITS (DEB_BITS)
    ) u_s2_deb (
        .hwclk  (hwclk),
        .reset  (reset),
        .btn_n  (s2_n),
        .stable (s2_stable)
    );

    // A step is one full extal period: it arms on a debounced press and
    // drops on the fall event, which is also where ctr wraps back to 0.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            s2_prev   <= 1'b1;
            step_pend <= 1'b0;
        end else begin
            s2_prev <= s2_stable;
            if (state != RUN) begin
                step_pend <= 1'b0;
            end else if (step_pend && ctr == CTR_MAX) begin
                step_pend <= 1'b0;
            end else if (!step_pend && s2_prev && !s2_stable) begin
                step_pend <= 1'b1;
            end
        end
    end

    // Reset sequencing must complete without presses, so only RUN gates ctr.
    assign ctr_en = (state != RUN) || step_pend;
`else
    logic unused_s2;
    assign unused_s2 = s2_n;
    assign ctr_en    = 1'b1;
`endif

    assign rise  = ctr_en && (ctr == CTR_MID);
    assign fall  = ctr_en && (ctr == CTR_MAX);
    assign extal = ctr[DIV_BITS-1];

    always_ff @(posedge hwclk) begin
        if (reset) begin
            ctr <= '0;
        end else if (ctr_en) begin
            ctr <= ctr + 1'b1;
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state   <= HOLD;
            rcnt    <= '0;
            reset_n <= 1'b0;
            running <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    reset_n <= 1'b0;
                    running <= 1'b0;
                    rcnt    <= '0;
                    if (s1_stable) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!s1_stable) begin
                        state <= HOLD;
                        rcnt  <= '0;
                    end else if (fall && rcnt == RC_MAX) begin
                        // Release on the same edge that drops extal.
                        state   <= RUN;
                        reset_n <= 1'b1;
                        running <= 1'b1;
                    end else if (rise && rcnt != RC_MAX) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!s1_stable) begin
                        state   <= HOLD;
                        reset_n <= 1'b0;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= HOLD;
                    rcnt    <= '0;
                    reset_n <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
